// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the sequential multiply/divide unit.
//   OP_MUL / OP_DIV : encodings of the 'op' request bit
//   state_e         : control FSM states (IDLE -> RUN -> FIX -> DONE)
package muldiv_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational sign handling around the unsigned engine.
//   Entry side : is_signed_i, a_i, b_i -> a_mag_o, b_mag_o (magnitudes),
//                sign_a_o, sign_b_o (operand signs, 0 in unsigned mode)
//   Exit side  : op_i, neg_hi_i, neg_lo_i, hi_raw_i, lo_raw_i -> hi_o, lo_o
//                multiply: neg_lo_i negates the whole 2*WIDTH product
//                divide  : neg_lo_i negates the quotient, neg_hi_i the remainder
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] a_mag_o,
    output logic [WIDTH-1:0] b_mag_o,
    output logic             sign_a_o,
    output logic             sign_b_o,
    input  logic             op_i,
    input  logic             neg_hi_i,
    input  logic             neg_lo_i,
    input  logic [WIDTH-1:0] hi_raw_i,
    input  logic [WIDTH-1:0] lo_raw_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;

    assign sign_a_o = is_signed_i & a_i[WIDTH-1];
    assign sign_b_o = is_signed_i & b_i[WIDTH-1];

    // -MIN wraps back to MIN, which read as unsigned is exactly |MIN|.
    assign a_mag_o = sign_a_o ? -a_i : a_i;
    assign b_mag_o = sign_b_o ? -b_i : b_i;

    assign prod_raw = {hi_raw_i, lo_raw_i};
    assign prod_fix = neg_lo_i ? -prod_raw : prod_raw;

    assign hi_o = (op_i == OP_MUL) ? prod_fix[2*WIDTH-1:WIDTH]
                                   : (neg_hi_i ? -hi_raw_i : hi_raw_i);
    assign lo_o = (op_i == OP_MUL) ? prod_fix[WIDTH-1:0]
                                   : (neg_lo_i ? -lo_raw_i : lo_raw_i);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential multiply/divide unit, one shared shift engine.
//   clock, reset (async, active-high)
//   start, op (0=mul, 1=div), a, b  : request, sampled only in IDLE
//   uns                             : unsigned operands (only with MULDIV_UNSIGNED_EN)
//   busy                            : high from the cycle after start through done
//   done, div0                      : one-cycle completion / divide-by-zero pulse
//   hi, lo                          : mul {upper,lower} product; div {remainder,quotient}
// Optional feature macro: MULDIV_UNSIGNED_EN (adds the uns port).
// Latency: start in cycle k -> done in cycle k+WIDTH+2 (k+1 for divide by zero).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
`ifdef MULDIV_UNSIGNED_EN
    input  logic             uns,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;   // mul: partial product; div: remainder
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;   // mul: multiplier/low product; div: dividend/quotient
    logic [WIDTH-1:0]   opb_q, opb_d;         // |b|: multiplicand or divisor
    logic               op_q, op_d;
    logic               neg_hi_q, neg_hi_d;
    logic               neg_lo_q, neg_lo_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

`ifdef MULDIV_UNSIGNED_EN
    assign is_signed = ~uns;
`else
    assign is_signed = 1'b1;
`endif

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .is_signed_i (is_signed),
        .a_i         (a),
        .b_i         (b),
        .a_mag_o     (a_mag),
        .b_mag_o     (b_mag),
        .sign_a_o    (sign_a),
        .sign_b_o    (sign_b),
        .op_i        (op_q),
        .neg_hi_i    (neg_hi_q),
        .neg_lo_i    (neg_lo_q),
        .hi_raw_i    (acc_hi_q),
        .lo_raw_i    (acc_lo_q),
        .hi_o        (fix_hi),
        .lo_o        (fix_lo)
    );

    // ------------------------------------------------------------------
    // Iteration engine: one radix-2 step per cycle.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    // Multiply: add |b| when the current multiplier bit is set, then shift
    // the {hi,lo} pair right; after WIDTH steps it holds the full product.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. The difference is below the divisor
    // whenever it is kept, so WIDTH bits of it are enough.
    assign div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = (div_trial >= {1'b0, opb_q});
    assign div_diff  = div_trial[WIDTH-1:0] - opb_q;

    // ------------------------------------------------------------------
    // Control FSM and datapath next-state.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        op_d     = op_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op;
                    acc_hi_d = '0;
                    acc_lo_d = a_mag;
                    opb_d    = b_mag;
                    cnt_d    = '0;
                    neg_lo_d = sign_a ^ sign_b;  // product / quotient sign
                    neg_hi_d = sign_a;           // remainder follows dividend
                    div0_d   = (op == OP_DIV) && (b == '0);
                    state_d  = ((op == OP_DIV) && (b == '0)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (op_q == OP_MUL) begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end else begin
                    acc_hi_d = div_ge ? div_diff : div_trial[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                state_d = S_DONE;
            end
            S_DONE: begin
                div0_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            op_q     <= OP_MUL;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign div0 = (state_q == S_DONE) & div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for muldiv_unit
// (WIDTH=32). Covers reset state, signed mul/div, divide by zero, MIN/-1,
// start while busy, mid-operation reset and back-to-back requests.
// With MULDIV_UNSIGNED_EN defined, unsigned vectors are exercised as well.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op    = OP_MUL;
    logic         uns   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, div0;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
`ifdef MULDIV_UNSIGNED_EN
        .uns   (uns),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Issues one request in the cycle after the previous done and follows it
    // to completion. poke_cyc > 0 fires a stray divide-by-zero start that
    // many cycles into the operation, which must be ignored.
    task automatic run_op(input string tag, input logic op_v, input logic uns_v,
                          input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input int exp_cyc, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input logic exp_div0,
                          input int poke_cyc);
        int           n;
        logic         held;
        logic [W-1:0] hi_prev, lo_prev;
        @(negedge clock);
        check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
        start = 1'b1; op = op_v; uns = uns_v; a = a_v; b = b_v;
        hi_prev = hi; lo_prev = lo; held = 1'b1; n = 0;
        do begin
            @(negedge clock);
            n++;
            // Operands must have been latched: scramble the inputs.
            start = 1'b0; op = ~op_v; a = ~a_v; b = ~b_v;
            if (n == 1) check({tag, "_busy"}, {63'd0, busy}, 64'd1);
            if (n == poke_cyc) begin
                start = 1'b1; op = OP_DIV; a = 32'd9; b = '0;
            end
            if (!done && (hi !== hi_prev || lo !== lo_prev)) held = 1'b0;
        end while (!done && n < 100);
        start = 1'b0;
        check({tag, "_cycle"}, 64'(n), 64'(exp_cyc));
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        check({tag, "_div0"}, {63'd0, div0}, {63'd0, exp_div0});
        check({tag, "_held"}, {63'd0, held}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen_done;

        repeat (2) @(negedge clock);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_div0", {63'd0, div0}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;

        //     tag          op      uns   a             b             cyc hi            lo            div0 poke
        run_op("mul_m1x2",  OP_MUL, 1'b0, 32'hFFFFFFFF, 32'h00000002, 34, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 0);
        run_op("div_7_m2",  OP_DIV, 1'b0, 32'h00000007, 32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0);
        run_op("div_pre",   OP_DIV, 1'b0, 32'h00000451, 32'h00000020, 34, 32'h00000011, 32'h00000022, 1'b0, 0);
        run_op("div_by0",   OP_DIV, 1'b0, 32'h00000005, 32'h00000000,  1, 32'h00000011, 32'h00000022, 1'b1, 0);
        run_op("div_min",   OP_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 1'b0, 0);
        run_op("mul_min",   OP_MUL, 1'b0, 32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h00000000, 1'b0, 0);
        run_op("div_m7_2",  OP_DIV, 1'b0, 32'hFFFFFFF9, 32'h00000002, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
        run_op("mul_m3m5",  OP_MUL, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFB, 34, 32'h00000000, 32'h0000000F, 1'b0, 0);
        run_op("div_100_7", OP_DIV, 1'b0, 32'h00000064, 32'h00000007, 34, 32'h00000002, 32'h0000000E, 1'b0, 0);
        run_op("mul_poke",  OP_MUL, 1'b0, 32'h12345678, 32'h00000100, 34, 32'h00000012, 32'h34567800, 1'b0, 5);

        // Reset at cycle 10 of a running multiply aborts it.
        @(negedge clock);
        start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd4;
        repeat (10) begin
            @(negedge clock);
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", {63'd0, seen_done}, 64'd0);
        run_op("mul_after", OP_MUL, 1'b0, 32'h00000003, 32'h00000004, 34, 32'h00000000, 32'h0000000C, 1'b0, 0);

`ifdef MULDIV_UNSIGNED_EN
        run_op("mulu_max",  OP_MUL, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
        run_op("divu_max",  OP_DIV, 1'b1, 32'hFFFFFFFF, 32'h00000002, 34, 32'h00000001, 32'h7FFFFFFF, 1'b0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
